apb_master: RTL and testbench
=============================

APB_MASTER -- requirements
Module: apb_master

Interface
REQ-001 SHALL have parameter NUM_SLV, default 2, meaning number of APB slaves (0=UART, 1=GPIO).
REQ-002 SHALL have parameter SLV_SEL_LSB, default 12, meaning LSB of the slave-index field in req_addr.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 16, meaning the maximum ACCESS cycles before abort (used only with the macro).
REQ-004 SHALL have port clk, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit; one clock, reset is asynchronous and active-low.
REQ-006 SHALL have ports req_valid (input, 1), req_ready (output, 1), req_write (input, 1), req_addr (input, 32) and req_wdata (input, 32), forming the command channel.
REQ-007 SHALL have ports rsp_valid (output, 1), rsp_ready (input, 1), rsp_rdata (output, 32) and rsp_err (output, 1), forming the response channel.
REQ-008 SHALL have ports paddr (output, 32), psel (output, NUM_SLV), penable (output, 1), pwrite (output, 1) and pwdata (output, 32), forming the APB request.
REQ-009 SHALL have ports prdata (input, 32*NUM_SLV, flattened, slave i at [32i+:32]), pready (input, NUM_SLV) and pslverr (input, NUM_SLV).

Function
REQ-010 SHALL implement FSM states IDLE, SETUP, ACCESS and RESP.
REQ-011 req_ready SHALL be 1 only in IDLE; a command is accepted when req_valid&&req_ready at a clock edge.
REQ-012 On accept: latch addr, wdata and write; idx=req_addr[SLV_SEL_LSB +: clog2(NUM_SLV)].
REQ-013 If idx>=NUM_SLV: no APB transfer; go to RESP with rsp_err=1, rsp_rdata=0.
REQ-014 Otherwise the FSM SHALL go to SETUP.
REQ-015 SETUP SHALL last exactly 1 cycle with psel[idx]=1 and penable=0, then go to ACCESS.
REQ-016 ACCESS SHALL drive psel[idx]=1 and penable=1 and hold until pready[idx]=1.
REQ-017 On pready[idx]=1: capture rsp_rdata=prdata[idx] (reads) or 0 (writes), capture rsp_err=pslverr[idx], deassert psel/penable, and go to RESP.
REQ-018 paddr, pwrite and pwdata SHALL stay constant from SETUP through the final ACCESS cycle; paddr holds its last value while idle.
REQ-019 At most one psel bit SHALL ever be high; psel=0 and penable=0 outside SETUP/ACCESS.
REQ-020 In RESP, rsp_valid SHALL be 1 with rsp_rdata/rsp_err stable until rsp_ready=1; then go to IDLE on the next edge.
REQ-021 Minimum latency: accept at edge N, SETUP in cycle N+1, ACCESS in N+2, rsp_valid in N+3 (pready=1 in the first ACCESS cycle).
REQ-022 Minimum back-to-back period SHALL be 4 cycles; no new SETUP starts before returning to IDLE.
REQ-023 pready/pslverr/prdata of non-selected slaves SHALL be ignored.
REQ-024 rsp_ready held at 1 SHALL make RESP last exactly 1 cycle.

Reset
REQ-025 rst=0 SHALL asynchronously force IDLE, with psel=0, penable=0, pwrite=0, paddr=0, pwdata=0, rsp_valid=0, rsp_rdata=0, rsp_err=0 and timeout counter=0.
REQ-026 Reset during SETUP/ACCESS/RESP SHALL abandon the transfer and its response, with no further bus activity.
REQ-027 req_ready SHALL be 1 from the first edge after rst release.

Configuration
REQ-028 With APB_MASTER_TIMEOUT_EN defined: a counter increments each ACCESS cycle without pready[idx]; when it reaches TIMEOUT_CYCLES, psel/penable SHALL deassert, rsp_err=1 and rsp_rdata=0, and the FSM goes to RESP; the counter clears on entering ACCESS.
REQ-029 Without APB_MASTER_TIMEOUT_EN: ACCESS SHALL wait indefinitely for pready; no counter logic is present.

Structure
REQ-030 Package apb_pkg SHALL hold the FSM state enum, ADDR_W=32, DATA_W=32, SLV_SEL_LSB and the slave index constants SLV_UART=0 and SLV_GPIO=1.
REQ-031 Sub-module apb_master_decode SHALL perform the combinational idx/psel one-hot decode, the decode-error flag and the prdata/pready/pslverr mux; no other sub-modules.

Verification
REQ-032 Write 0x0000_1004 data 0xA5 with pready=1 immediately -> psel=2'b10 for 2 cycles, penable in cycle 2, rsp_valid at N+3, rsp_err=0.
REQ-033 Read 0x0000_0008, slave0 pready low 3 cycles, prdata=0x55 -> ACCESS lasts 4 cycles, rsp_rdata=0x55, paddr stable throughout.
REQ-034 Read with pslverr=1 at pready -> rsp_err=1; rsp_ready held low 5 cycles -> rsp_valid/rsp_rdata stable and req_ready=0 until release.
REQ-035 NUM_SLV=2 with slave 3 addressed (SLV_SEL_LSB field=3) -> no psel pulse, rsp_err=1, rsp_rdata=0.
REQ-036 rst asserted in ACCESS -> psel/penable drop immediately with no rsp_valid; macro on with pready stuck low -> rsp_err=1 after 16 ACCESS cycles.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared APB master definitions: bus widths, slave map and FSM state encoding.
package apb_pkg;
  localparam int ADDR_W      = 32;
  localparam int DATA_W      = 32;
  localparam int SLV_SEL_LSB = 12;

  // Slave map
  localparam int SLV_UART = 0;
  localparam int SLV_GPIO = 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_state_e;
endpackage

// File: rtl/apb_master_decode.sv
// Slave decode: index -> one-hot psel, out-of-range flag, and the return-path
// mux that selects prdata/pready/pslverr of the addressed slave only.
module apb_master_decode
  import apb_pkg::*;
#(
  parameter int NUM_SLV = 2,
  parameter int IDX_W   = 2
)(
  input  logic [IDX_W-1:0]          i_idx,
  input  logic [DATA_W*NUM_SLV-1:0] i_prdata,
  input  logic [NUM_SLV-1:0]        i_pready,
  input  logic [NUM_SLV-1:0]        i_pslverr,
  output logic [NUM_SLV-1:0]        o_sel,
  output logic                      o_dec_err,
  output logic [DATA_W-1:0]         o_rdata,
  output logic                      o_ready,
  output logic                      o_slverr
);

  // One-hot select and return mux; an index with no matching slave flags an error
  always_comb begin
    o_sel     = '0;
    o_dec_err = 1'b1;
    o_rdata   = '0;
    o_ready   = 1'b0;
    o_slverr  = 1'b0;
    for (int i = 0; i < NUM_SLV; i++) begin
      if (i_idx == IDX_W'(i)) begin
        o_sel[i]  = 1'b1;
        o_dec_err = 1'b0;
        o_rdata   = i_prdata[DATA_W*i +: DATA_W];
        o_ready   = i_pready[i];
        o_slverr  = i_pslverr[i];
      end
    end
  end

endmodule

// File: rtl/apb_master.sv
// APB master bridge: one command at a time through IDLE/SETUP/ACCESS/RESP.
// Optional ACCESS timeout enabled by defining APB_MASTER_TIMEOUT_EN.
module apb_master
  import apb_pkg::*;
#(
  parameter int NUM_SLV        = 2,
  parameter int SLV_SEL_LSB    = apb_pkg::SLV_SEL_LSB,
  parameter int TIMEOUT_CYCLES = 16
)(
  input  logic                      clk,
  input  logic                      rst,
  // command channel
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_write,
  input  logic [ADDR_W-1:0]         req_addr,
  input  logic [DATA_W-1:0]         req_wdata,
  // response channel
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      rsp_err,
  // APB
  output logic [ADDR_W-1:0]         paddr,
  output logic [NUM_SLV-1:0]        psel,
  output logic                      penable,
  output logic                      pwrite,
  output logic [DATA_W-1:0]         pwdata,
  input  logic [DATA_W*NUM_SLV-1:0] prdata,
  input  logic [NUM_SLV-1:0]        pready,
  input  logic [NUM_SLV-1:0]        pslverr
);

  // The index field is one bit wider than strictly needed for NUM_SLV slaves
  // whenever NUM_SLV is a power of two, so addresses beyond the last slave
  // decode as errors instead of aliasing onto a real slave.
  localparam int IDX_W = (NUM_SLV < 1) ? 1 : $clog2(NUM_SLV + 1);

  if (NUM_SLV < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("apb_master: NUM_SLV and TIMEOUT_CYCLES must be >= 1");
  end

  apb_state_e          r_state;
  logic [NUM_SLV-1:0]  r_psel;
  logic                r_penable;
  logic                r_pwrite;
  logic [ADDR_W-1:0]   r_paddr;
  logic [DATA_W-1:0]   r_pwdata;
  logic                r_rsp_valid;
  logic [DATA_W-1:0]   r_rsp_rdata;
  logic                r_rsp_err;

  logic [IDX_W-1:0]    w_idx;
  logic [NUM_SLV-1:0]  w_sel;
  logic                w_dec_err;
  logic [DATA_W-1:0]   w_rdata;
  logic                w_ready;
  logic                w_slverr;
  logic                w_tout;

  // In IDLE decode the incoming command; afterwards decode the latched address
  assign w_idx = (r_state == IDLE) ? req_addr[SLV_SEL_LSB +: IDX_W]
                                   : r_paddr[SLV_SEL_LSB +: IDX_W];

  apb_master_decode #(
    .NUM_SLV (NUM_SLV),
    .IDX_W   (IDX_W)
  ) u_decode (
    .i_idx     (w_idx),
    .i_prdata  (prdata),
    .i_pready  (pready),
    .i_pslverr (pslverr),
    .o_sel     (w_sel),
    .o_dec_err (w_dec_err),
    .o_rdata   (w_rdata),
    .o_ready   (w_ready),
    .o_slverr  (w_slverr)
  );

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int TCNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TCNT_W-1:0] r_tcnt;

  // Abort on the ACCESS cycle that brings the no-pready count up to TIMEOUT_CYCLES
  assign w_tout = (r_state == ACCESS) && !w_ready &&
                  (r_tcnt == TCNT_W'(TIMEOUT_CYCLES - 1));

  // Count ACCESS cycles without pready; cleared on the way into ACCESS
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                              r_tcnt <= '0;
    else if (r_state == SETUP)             r_tcnt <= '0;
    else if (r_state == ACCESS && !w_ready) r_tcnt <= r_tcnt + 1'b1;
  end
`else
  assign w_tout = 1'b0;
`endif

  // Main transfer FSM with registered APB and response outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_psel      <= '0;
      r_penable   <= 1'b0;
      r_pwrite    <= 1'b0;
      r_paddr     <= '0;
      r_pwdata    <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_paddr  <= req_addr;
            r_pwdata <= req_wdata;
            r_pwrite <= req_write;
            if (w_dec_err) begin
              // No slave behind this index: answer locally, no bus cycle
              r_rsp_valid <= 1'b1;
              r_rsp_err   <= 1'b1;
              r_rsp_rdata <= '0;
              r_state     <= RESP;
            end else begin
              r_psel  <= w_sel;
              r_state <= SETUP;
            end
          end
        end
        SETUP: begin
          r_penable <= 1'b1;
          r_state   <= ACCESS;
        end
        ACCESS: begin
          if (w_ready) begin
            r_psel      <= '0;
            r_penable   <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= w_slverr;
            r_rsp_rdata <= r_pwrite ? '0 : w_rdata;
            r_state     <= RESP;
          end else if (w_tout) begin
            r_psel      <= '0;
            r_penable   <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= 1'b1;
            r_rsp_rdata <= '0;
            r_state     <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign req_ready = (r_state == IDLE);
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;
  assign paddr     = r_paddr;
  assign psel      = r_psel;
  assign penable   = r_penable;
  assign pwrite    = r_pwrite;
  assign pwdata    = r_pwdata;

endmodule

// File: tb/tb_apb_master.sv
// Bench for apb_master: directed corner transfers plus random transfers,
// each checked against a transaction-level expectation of the bridge.
module tb_apb_master;
  import apb_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0, req_write = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        rsp_valid, rsp_err;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic [31:0] paddr, pwdata;
  logic [1:0]  psel;
  logic        penable, pwrite;
  logic [63:0] prdata = '0;
  logic [1:0]  pready = '0, pslverr = '0;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  apb_master dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite), .pwdata(pwdata),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One command through the bridge. wait_n = ACCESS cycles the slave holds
  // pready low; hold = cycles rsp_ready is held low in RESP.
  task automatic do_txn(input string nm, input bit wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input int wait_n, input bit serr,
                        input logic [31:0] rdv, input int hold);
    int idx, lat, nsel, nacc, exp_acc, exp_lat;
    bit bad, tout, bus_ok, hold_ok, exp_err;
    logic [31:0] exp_rd, snap_rd;
    logic        snap_err;
    idx  = int'((addr >> 12) & 32'd3);
    bad  = (idx >= 2);
    tout = 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
    if (!bad && wait_n >= 16) tout = 1'b1;
`endif
    exp_err = bad || tout || serr;
    exp_rd  = (bad || tout || wr) ? 32'd0 : rdv;
    exp_acc = bad ? 0 : (tout ? 16 : wait_n + 1);
    exp_lat = bad ? 1 : 2 + exp_acc;

    chk({nm, ".req_ready"}, req_ready, 1);
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wdata;
    @(negedge clk);
    // scramble the command inputs: the bus must run on the latched copy
    req_valid = 1'b0; req_write = ~wr; req_addr = $urandom; req_wdata = $urandom;
    lat = 1; nsel = 0; nacc = 0; bus_ok = 1'b1;
    while (!rsp_valid && lat < 300) begin
      if (psel != 2'b00) begin
        nsel++;
        if (bad || psel != (2'b01 << idx)) bus_ok = 1'b0;
        if (paddr !== addr || pwrite !== wr || pwdata !== wdata) bus_ok = 1'b0;
      end
      if (penable) begin
        nacc++;
        if (psel == 2'b00) bus_ok = 1'b0;
      end
      if (req_ready) bus_ok = 1'b0;
      // unselected slaves and the selected one outside its response cycle emit noise
      pready = 2'($urandom); pslverr = 2'($urandom); prdata = {$urandom, $urandom};
      if (!bad && penable) begin
        pready[idx] = (nacc > wait_n);
        if (nacc > wait_n) begin
          pslverr[idx] = serr;
          prdata[idx*32 +: 32] = rdv;
        end
      end
      @(negedge clk);
      lat++;
    end
    chk({nm, ".latency"}, lat, exp_lat);
    chk({nm, ".psel_cycles"}, nsel, bad ? 0 : exp_acc + 1);
    chk({nm, ".access_cycles"}, nacc, exp_acc);
    chk({nm, ".bus_ok"}, bus_ok, 1);
    chk({nm, ".rsp_err"}, rsp_err, exp_err);
    chk({nm, ".rsp_rdata"}, rsp_rdata, exp_rd);

    snap_rd = rsp_rdata; snap_err = rsp_err; hold_ok = 1'b1;
    repeat (hold) begin
      pready = 2'($urandom); pslverr = 2'($urandom); prdata = {$urandom, $urandom};
      @(negedge clk);
      if (!rsp_valid || rsp_rdata !== snap_rd || rsp_err !== snap_err ||
          req_ready || psel != 2'b00 || penable) hold_ok = 1'b0;
    end
    if (hold > 0) chk({nm, ".resp_hold"}, hold_ok, 1);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk({nm, ".resp_done"}, {rsp_valid, req_ready, psel, penable}, 5'b01000);
  endtask

  initial begin
    int field;
    logic [31:0] a;
    #2 rst = 1'b0;
    #1;
    chk("reset_outputs", {req_ready, rsp_valid, rsp_err, psel, penable, pwrite},
        {1'b1, 6'b0});
    chk("reset_data", {paddr, pwdata, rsp_rdata}, 96'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("req_ready_after_rst", req_ready, 1);

    // Directed corners
    do_txn("wr_gpio",    1'b1, 32'h0000_1004, 32'h0000_00A5, 0, 1'b0, 32'hDEAD_BEEF, 0);
    do_txn("rd_uart_w3", 1'b0, 32'h0000_0008, 32'h0,         3, 1'b0, 32'h0000_0055, 0);
    do_txn("rd_slverr",  1'b0, 32'h0000_1010, 32'h0,         1, 1'b1, 32'h0000_0077, 5);
    do_txn("dec_err",    1'b0, 32'h0000_3000, 32'h0,         0, 1'b0, 32'h1234_5678, 0);
`ifdef APB_MASTER_TIMEOUT_EN
    do_txn("timeout",    1'b0, 32'h0000_0020, 32'h0,       100, 1'b0, 32'h0000_0001, 0);
`endif

    // Reset in ACCESS abandons the transfer immediately
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h0000_1000; req_wdata = 32'h0;
    pready = 2'b00;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk("rst_mid.in_access", {psel, penable}, 3'b101);
    rst = 1'b0;
    #1;
    chk("rst_mid.drop", {psel, penable, rsp_valid}, 4'b0000);
    pready = 2'b11; rsp_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("rst_mid.quiet", {psel, penable, rsp_valid}, 4'b0000);
    end
    rst = 1'b1; rsp_ready = 1'b0; pready = 2'b00;
    @(negedge clk);
    chk("rst_mid.idle", {req_ready, rsp_valid, psel}, 4'b1000);

    // Random traffic, including out-of-range indices
    for (int t = 0; t < 40; t++) begin
      field = $urandom_range(0, 3);
      a = $urandom;
      a[13:12] = 2'(field);
      do_txn("rand", 1'($urandom), a, $urandom, $urandom_range(0, 4),
             1'($urandom), $urandom, $urandom_range(0, 3));
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
